// File: rtl/cp0_irq.sv
// MIPS CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Handles MTC0 writes, exception/ERET commits, the Count/Compare timer and interrupt requests.
module cp0_irq #(
   parameter int unsigned HW_INT_NUM = 6,
   parameter int unsigned COUNT_DIV  = 2,
   parameter int unsigned TIMER_IP   = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4:0]            raddr,
   output logic [31:0]           rdata,
   input  logic                  wen,
   input  logic [4:0]            waddr,
   input  logic [31:0]           wdata,
   input  logic                  ex_valid,
   input  logic [4:0]            ex_code,
   input  logic [31:0]           ex_pc,
   input  logic                  bd,
   input  logic [31:0]           badvaddr,
   input  logic                  eret,
   input  logic [HW_INT_NUM-1:0] hw_int,
   output logic                  int_req,
   output logic [31:0]           epc,
   output logic                  exl
);

   localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;

   logic [31:0]   r_badvaddr;
   logic [31:0]   r_count;
   logic [31:0]   r_compare;
   logic [31:0]   r_epc;
   logic [PW-1:0] r_presc;
   logic [7:0]    r_im;
   logic          r_exl;
   logic          r_ie;
   logic          r_bd;
   logic          r_ti;
   logic [5:0]    r_hw_ip;
   logic [1:0]    r_sw_ip;
   logic [4:0]    r_exccode;

   logic          w_mtc0;
   logic          w_wr_count;
   logic          w_wr_compare;
   logic          w_tick;
   logic          w_match;
   logic [5:0]    w_hw_ext;
   logic [7:0]    w_ti_ip;
   logic [7:0]    w_ip;
   logic [31:0]   w_status;
   logic [31:0]   w_cause;

   // MTC0 only takes effect when no exception or ERET commits in the same cycle
   assign w_mtc0       = wen & ~ex_valid & ~eret;
   assign w_wr_count   = w_mtc0 && (waddr == REG_COUNT);
   assign w_wr_compare = w_mtc0 && (waddr == REG_COMPARE);
   assign w_tick       = (r_presc == PRESC_MAX);
   assign w_match      = (r_count == r_compare);

   always_comb begin
      w_hw_ext = '0;
      for (int unsigned i = 0; i < HW_INT_NUM; i++) begin
         if (i < 6) w_hw_ext[i] = hw_int[i];
      end
   end

   assign w_ti_ip  = r_ti ? (8'd1 << TIMER_IP) : 8'd0;
   assign w_ip     = {r_hw_ip, r_sw_ip} | w_ti_ip;
   assign w_status = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
   assign w_cause  = {r_bd, r_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b0};

   // Count prescaler, Compare and timer-interrupt flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count   <= '0;
         r_presc   <= '0;
         r_compare <= 32'hFFFF_FFFF;
         r_ti      <= 1'b0;
      end else begin
         if (w_wr_count) begin
            r_count <= wdata;
            r_presc <= '0;
         end else if (w_tick) begin
            r_count <= r_count + 32'd1;
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + PW'(1);
         end
         if (w_wr_compare) begin
            r_compare <= wdata;
            r_ti      <= 1'b0;
         end else if (w_match) begin
            r_ti <= 1'b1;
         end
      end
   end

   // Hardware interrupt lines are sampled once per cycle into IP[7:2]
   always_ff @(posedge clk) begin
      if (reset) r_hw_ip <= '0;
      else       r_hw_ip <= w_hw_ext;
   end

   // Exception commit, ERET and MTC0 to Status/Cause/EPC, in priority order
   always_ff @(posedge clk) begin
      if (reset) begin
         r_badvaddr <= '0;
         r_epc      <= '0;
         r_im       <= '0;
         r_exl      <= 1'b0;
         r_ie       <= 1'b0;
         r_bd       <= 1'b0;
         r_sw_ip    <= '0;
         r_exccode  <= '0;
      end else if (ex_valid) begin
         if (!r_exl) begin
            r_epc <= bd ? (ex_pc - 32'd4) : ex_pc;
            r_bd  <= bd;
         end
         r_exccode <= ex_code;
         r_exl     <= 1'b1;
         if (ex_code == 5'd4 || ex_code == 5'd5) r_badvaddr <= badvaddr;
      end else if (eret) begin
         r_exl <= 1'b0;
      end else if (wen) begin
         case (waddr)
            REG_STATUS: begin
               r_im  <= wdata[15:8];
               r_exl <= wdata[1];
               r_ie  <= wdata[0];
            end
            REG_CAUSE: r_sw_ip <= wdata[9:8];
            REG_EPC:   r_epc   <= wdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      case (raddr)
         REG_BADVADDR: rdata = r_badvaddr;
         REG_COUNT:    rdata = r_count;
         REG_COMPARE:  rdata = r_compare;
         REG_STATUS:   rdata = w_status;
         REG_CAUSE:    rdata = w_cause;
         REG_EPC:      rdata = r_epc;
         default:      rdata = '0;
      endcase
   end

   assign int_req = r_ie & ~r_exl & (|(w_ip & r_im));
   assign epc     = r_epc;
   assign exl     = r_exl;

endmodule

// File: tb/tb_cp0_irq.sv
// Directed self-checking bench for cp0_irq with hand-computed expected values.
module tb_cp0_irq;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  raddr;
   logic [31:0] rdata;
   logic        wen;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        ex_valid;
   logic [4:0]  ex_code;
   logic [31:0] ex_pc;
   logic        bd;
   logic [31:0] badvaddr;
   logic        eret;
   logic [5:0]  hw_int;
   logic        int_req;
   logic [31:0] epc;
   logic        exl;

   int n_vec = 0;
   int n_err = 0;

   cp0_irq #(.HW_INT_NUM(6), .COUNT_DIV(2), .TIMER_IP(7)) dut (
      .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata),
      .wen(wen), .waddr(waddr), .wdata(wdata),
      .ex_valid(ex_valid), .ex_code(ex_code), .ex_pc(ex_pc), .bd(bd),
      .badvaddr(badvaddr), .eret(eret), .hw_int(hw_int),
      .int_req(int_req), .epc(epc), .exl(exl)
   );

   always #10 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
      raddr = a;
      #1;
      chk(tag, rdata, exp);
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      wen = 1'b1; waddr = a; wdata = d;
      step();
      wen = 1'b0;
   endtask

   initial begin
      reset = 1'b1; raddr = '0; wen = 1'b0; waddr = '0; wdata = '0;
      ex_valid = 1'b0; ex_code = '0; ex_pc = '0; bd = 1'b0; badvaddr = '0;
      eret = 1'b0; hw_int = '0;
      @(negedge clk);
      step();
      step();
      rd("rst_status", 5'd12, 32'h0040_0000);
      rd("rst_cause", 5'd13, 32'h0);
      rd("rst_compare", 5'd11, 32'hFFFF_FFFF);
      rd("rst_count", 5'd9, 32'h0);
      chk("rst_int_req", 32'(int_req), 32'h0);
      chk("rst_epc", epc, 32'h0);
      reset = 1'b0;

      // Timer: Compare=5, IM=0x80, IE=1, Count restarted at 0
      mtc0(5'd11, 32'd5);
      mtc0(5'd12, 32'h0000_8001);
      mtc0(5'd9, 32'd0);
      repeat (10) step();
      rd("tmr_count5", 5'd9, 32'd5);
      chk("tmr_pre_irq", 32'(int_req), 32'h0);
      rd("tmr_pre_cause", 5'd13, 32'h0);
      step();
      chk("tmr_irq", 32'(int_req), 32'h1);
      rd("tmr_cause_ti", 5'd13, 32'h4000_8000);
      rd("tmr_count_hold", 5'd9, 32'd5);
      // Compare write coincides with a still-true match: clear wins
      mtc0(5'd11, 32'd20);
      chk("tmr_clr_irq", 32'(int_req), 32'h0);
      rd("tmr_clr_cause", 5'd13, 32'h0);
      rd("tmr_compare20", 5'd11, 32'd20);
      mtc0(5'd11, 32'h8000_0000);

      // Exception in a delay slot with address error
      ex_valid = 1'b1; ex_code = 5'd4; bd = 1'b1;
      ex_pc = 32'hBFC0_0104; badvaddr = 32'h1234_5671;
      step();
      ex_valid = 1'b0;
      chk("exc_epc", epc, 32'hBFC0_0100);
      rd("exc_cause", 5'd13, 32'h8000_0010);
      rd("exc_badvaddr", 5'd8, 32'h1234_5671);
      chk("exc_exl", 32'(exl), 32'h1);
      rd("exc_status", 5'd12, 32'h0040_8003);

      // Nested exception: EPC and BD held, ExcCode updated, BadVAddr untouched
      ex_valid = 1'b1; ex_code = 5'd10; bd = 1'b0;
      ex_pc = 32'h0; badvaddr = 32'hDEAD_BEEF;
      step();
      ex_valid = 1'b0;
      chk("exc2_epc", epc, 32'hBFC0_0100);
      rd("exc2_cause", 5'd13, 32'h8000_0028);
      rd("exc2_badvaddr", 5'd8, 32'h1234_5671);

      // ERET beats a concurrent MTC0 to Status
      eret = 1'b1; wen = 1'b1; waddr = 5'd12; wdata = 32'h0;
      step();
      eret = 1'b0; wen = 1'b0;
      chk("eret_exl", 32'(exl), 32'h0);
      rd("eret_status", 5'd12, 32'h0040_8001);

      // ex_valid beats eret
      ex_valid = 1'b1; eret = 1'b1; ex_code = 5'd0; bd = 1'b0; ex_pc = 32'h8000_0180;
      step();
      ex_valid = 1'b0; eret = 1'b0;
      chk("exeret_exl", 32'(exl), 32'h1);
      chk("exeret_epc", epc, 32'h8000_0180);
      rd("exeret_cause", 5'd13, 32'h0);
      eret = 1'b1;
      step();
      eret = 1'b0;
      chk("eret2_exl", 32'(exl), 32'h0);

      // Hardware interrupt with one cycle of sampling latency
      mtc0(5'd12, 32'h0000_0401);
      hw_int = 6'b000001;
      #1;
      chk("hw_latency", 32'(int_req), 32'h0);
      step();
      chk("hw_irq", 32'(int_req), 32'h1);
      rd("hw_cause", 5'd13, 32'h0000_0400);
      mtc0(5'd12, 32'h0000_0403);
      chk("hw_exl_mask", 32'(int_req), 32'h0);
      chk("hw_exl", 32'(exl), 32'h1);
      hw_int = '0;
      mtc0(5'd12, 32'h0000_0401);
      chk("hw_release", 32'(int_req), 32'h0);
      rd("hw_cause_clr", 5'd13, 32'h0);

      // Software interrupt; only IP[1:0] of Cause are writable
      mtc0(5'd12, 32'h0000_0101);
      mtc0(5'd13, 32'h0000_0100);
      chk("sw_irq", 32'(int_req), 32'h1);
      rd("sw_cause", 5'd13, 32'h0000_0100);
      mtc0(5'd13, 32'hFFFF_FFFF);
      rd("sw_cause_mask", 5'd13, 32'h0000_0300);
      mtc0(5'd13, 32'h0);
      chk("sw_clr", 32'(int_req), 32'h0);

      // Count wraps after COUNT_DIV cycles
      mtc0(5'd9, 32'hFFFF_FFFF);
      rd("wrap_load", 5'd9, 32'hFFFF_FFFF);
      step();
      rd("wrap_hold", 5'd9, 32'hFFFF_FFFF);
      step();
      rd("wrap_zero", 5'd9, 32'h0);

      // EPC write: old value readable until the edge
      wen = 1'b1; waddr = 5'd14; wdata = 32'h0000_1000;
      rd("epc_old", 5'd14, 32'h8000_0180);
      step();
      wen = 1'b0;
      rd("epc_new", 5'd14, 32'h0000_1000);
      chk("epc_port", epc, 32'h0000_1000);

      // BadVAddr is read-only; unimplemented registers read 0
      mtc0(5'd8, 32'h0);
      rd("bva_ro", 5'd8, 32'h1234_5671);
      rd("unimpl0", 5'd0, 32'h0);
      rd("unimpl31", 5'd31, 32'h0);

      // Reset mid-operation overrides exception, eret and MTC0
      reset = 1'b1; ex_valid = 1'b1; ex_code = 5'd5; eret = 1'b1;
      wen = 1'b1; waddr = 5'd12; wdata = 32'hFFFF_FFFF;
      step();
      reset = 1'b0; ex_valid = 1'b0; eret = 1'b0; wen = 1'b0;
      rd("mrst_status", 5'd12, 32'h0040_0000);
      rd("mrst_bva", 5'd8, 32'h0);
      chk("mrst_exl", 32'(exl), 32'h0);
      chk("mrst_epc", epc, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cp0_irq.md
# cp0_irq

Parametrised MIPS CP0 register file with timer and interrupt support, successor to the first-generation exception-only CP0. It holds BadVAddr, Count, Compare, Status, Cause and EPC. It accepts MTC0 writes and exception/ERET events from the writeback stage, and samples external hardware interrupt lines. It raises a single interrupt request toward the pipeline's exception logic.

## Interface
Parameters:
- HW_INT_NUM, 6: number of hardware interrupt lines (1..6), mapped to Cause.IP[2+HW_INT_NUM-1:2]; unused IP bits read 0.
- COUNT_DIV, 2: Count increments once every COUNT_DIV cycles (1..16).
- TIMER_IP, 7: IP bit that carries the timer interrupt (OR'd with any hw line on that bit).

Ports (the CP0 stores and reads nothing else):
- clk, in, 1: clock; all state updates on rising edge.
- reset, in, 1: synchronous, active-high reset.
- raddr, in, 5: MFC0 register number.
- rdata, out, 32: combinational read data; 0 for unimplemented registers.
- wen, in, 1: MTC0 write strobe.
- waddr, in, 5: MTC0 register number.
- wdata, in, 32: MTC0 data.
- ex_valid, in, 1: exception commit this cycle.
- ex_code, in, 5: ExcCode of the committing exception (0 = Int is legal).
- ex_pc, in, 32: PC of the faulting instruction.
- bd, in, 1: faulting instruction is in a delay slot.
- badvaddr, in, 32: faulting address for AdEL/AdES.
- eret, in, 1: ERET commit this cycle.
- hw_int, in, HW_INT_NUM: level-sensitive external interrupts.
- int_req, out, 1: interrupt pending and enabled.
- epc, out, 32: current EPC (ERET target).
- exl, out, 1: current Status.EXL.

## Operation
Register numbers:
- BadVAddr=8, read-only.
- Count=9, rw.
- Compare=11, rw.
- Status=12.
- Cause=13.
- EPC=14, rw.

Status:
- Layout: {9'b0, BEV, 6'b0, IM[7:0], 6'b0, EXL, IE}.
- BEV is constant 1.
- IM, EXL and IE are MTC0-writable.

Cause:
- Layout: {BD, TI, 14'b0, IP[7:0], 1'b0, ExcCode, 2'b0}.
- Only IP[1:0] are MTC0-writable.
- IP[7:2] are re-sampled every cycle from hw_int, with TI OR'd into IP[TIMER_IP].

Count and Compare:
- A prescaler counts 0..COUNT_DIV-1. Count increments (32-bit wrap) when the prescaler is at COUNT_DIV-1.
- TI sets on the cycle after Count (post-update) equals Compare.
- TI clears on any MTC0 to Compare.

Exception (ex_valid=1):
- If EXL=0: EPC ← bd ? ex_pc−4 : ex_pc, and Cause.BD ← bd.
- Always: ExcCode ← ex_code, EXL ← 1.
- BadVAddr ← badvaddr only when ex_code is 4 (AdEL) or 5 (AdES).

ERET: EXL ← 0.

int_req = IE & ~EXL & |(IP[7:0] & IM[7:0]).

Priority, highest first:
1. reset
2. ex_valid
3. eret
4. MTC0

Same-cycle conflicts:
- An MTC0 in the same cycle as ex_valid or eret is dropped.
- An MTC0 to Count in the same cycle as an increment: the written value wins, and the prescaler restarts at 0.
- A Count==Compare match together with an MTC0 to Compare: the clear wins.

## Timing
- rdata, epc and exl are combinational from the registers. A read in the same cycle as a write returns the old value; the new value is visible next cycle.
- int_req reflects hw_int with one cycle of latency (IP is registered).
- Timer: TI is visible one cycle after the match.

Reset values:
- Status = 0x0040_0000 (BEV=1, IM=0, EXL=0, IE=0).
- Cause = 0.
- Count = 0, prescaler = 0.
- Compare = 0xFFFF_FFFF.
- BadVAddr = 0.
- EPC = 0.
- int_req = 0.

Reset mid-operation overrides any concurrent ex_valid, eret or MTC0.

## Test plan
- **Reset:** after reset, read 12 → 0x0040_0000, read 13 → 0, read 11 → 0xFFFF_FFFF, int_req=0.
- **Timer:** COUNT_DIV=2; write Compare=5, IM=0x80, IE=1. Count reaches 5 at cycle ~10 → TI=1 and int_req=1 the next cycle. Then write Compare=20 → TI=0, int_req=0.
- **Exception in delay slot:** ex_valid, ex_code=4, bd=1, ex_pc=0xBFC0_0104, badvaddr=0x1234_5671 → EPC=0xBFC0_0100, Cause=0x8000_0010, BadVAddr=0x1234_5671, exl=1. A second exception with ex_pc=0x0 leaves EPC unchanged and updates ExcCode.
- **ERET vs MTC0 priority:** eret together with an MTC0 to Status writing 0x0 → EXL=0, IE unchanged. ex_valid together with eret → EXL=1.
- **Hardware interrupt:** hw_int[0]=1, IM=0x04, IE=1 → IP[2]=1 and int_req=1 one cycle later. The same with EXL=1 → int_req=0.
- **Software interrupt and Count wrap:** MTC0 Cause=0x100 with IM=0x01, IE=1 → int_req=1. Write Count=0xFFFF_FFFF → wraps to 0 after COUNT_DIV cycles.
